// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 definitions for the host transmitter and the
//                receiver: transmitter state encoding, odd-parity helper and
//                default line timing at a 50 MHz system clock.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Default timing in system clock cycles (50 MHz)
    localparam int c_INHIBIT_CYCLES = 5000;     // 100 us clock inhibit before request
    localparam int c_REQ_CYCLES     = 50;       // data low with clock still held low
    localparam int c_TIMEOUT_CYCLES = 750000;   // 15 ms without any device clock fall
    localparam int c_FILTER_LEN     = 4;        // equal samples to accept a clock change

    // The bit counter counts device clock falls; fall 11 is the ACK slot
    localparam logic [3:0] c_BITCNT_MAX = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_ERR       = 3'd6
    } ps2_tx_state_t;

    // Parity bit that makes the total number of ones in data+parity odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_sync_edge
//  Description : Two-flop synchronizer followed by a glitch filter for a raw
//                PS/2 line. The filtered level only changes after FILTER_LEN
//                consecutive synchronized samples disagree with it; a one-cycle
//                fall pulse accompanies every accepted 1->0 change.
//  Ports       : clk    in   system clock
//                rst_n  in   asynchronous active-low reset
//                din    in   raw asynchronous line
//                level  out  filtered line level (idle high)
//                fall   out  one-cycle pulse on filtered 1->0 change
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_sync_edge
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = c_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    localparam int c_CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_LEN - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_level;
    logic               r_fall;
    logic [c_CNT_W-1:0] r_cnt;

    // Lines idle high, so every stage resets to 1 to avoid a fake edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_fall <= 1'b0;
            if (r_sync != r_level) begin
                // This sample is the FILTER_LEN-th in a row that disagrees
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= r_sync;
                    r_fall  <= ~r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 transmitter. Sends one command byte to
//                the keyboard over the open-drain clock/data lines, which it
//                only ever pulls low through output enables.
//  Ports       : clk        in   system clock
//                rst_n      in   asynchronous active-low reset
//                tx_data    in   byte to send
//                tx_valid   in   send request, taken when tx_ready is high
//                tx_ready   out  idle, can accept a byte
//                tx_done    out  one-cycle pulse: byte sent and ACKed
//                tx_err     out  one-cycle pulse: timeout or NACK
//                busy       out  transfer in progress (gates the receiver)
//                ps2clk_i   in   raw clock line
//                ps2dat_i   in   raw data line
//                ps2clk_oe  out  1 = pull clock line low
//                ps2dat_oe  out  1 = pull data line low
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = c_INHIBIT_CYCLES,
    parameter int REQ_CYCLES     = c_REQ_CYCLES,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = c_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2clk_i,
    input  logic       ps2dat_i,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe
);

    localparam int c_INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int c_REQ_W = (REQ_CYCLES     > 1) ? $clog2(REQ_CYCLES)     : 1;
    localparam int c_TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_REQ_W-1:0] c_REQ_LAST = c_REQ_W'(REQ_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t      r_state;
    logic               r_ready;
    logic               r_done;
    logic               r_err;
    logic               r_clk_oe;
    logic               r_dat_oe;
    logic [7:0]         r_data;
    logic               r_parity;
    logic [3:0]         r_bit_cnt;
    logic [c_INH_W-1:0] r_inh_cnt;
    logic [c_REQ_W-1:0] r_req_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               r_dat_meta;
    logic               r_dat_sync;

    logic               w_clk_level;
    logic               w_clk_fall;
    logic               w_timeout;

    ps2_sync_edge #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2clk_i),
        .level (w_clk_level),
        .fall  (w_clk_fall)
    );

    // Data line is only sampled at filtered clock falls, so a plain
    // synchronizer is enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_dat_meta <= ps2dat_i;
            r_dat_sync <= r_dat_meta;
        end
    end

    // A clock fall in the same cycle always wins over expiry
    assign w_timeout = (r_to_cnt == c_TO_LAST) && !w_clk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_req_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && r_ready) begin
                        r_data    <= tx_data;
                        r_parity  <= odd_parity(tx_data);
                        r_bit_cnt <= '0;
                        r_inh_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_ready   <= 1'b0;
                        r_state   <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (r_inh_cnt == c_INH_LAST) begin
                        r_dat_oe  <= 1'b1;          // start bit
                        r_req_cnt <= '0;
                        r_state   <= ST_REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + c_INH_W'(1);
                    end
                end

                ST_REQ: begin
                    if (r_req_cnt == c_REQ_LAST) begin
                        r_clk_oe <= 1'b0;           // hand the clock to the device
                        r_to_cnt <= '0;
                        r_state  <= ST_SEND;
                    end else begin
                        r_req_cnt <= r_req_cnt + c_REQ_W'(1);
                    end
                end

                ST_SEND, ST_ACK: begin
                    if (w_clk_fall) begin
                        r_to_cnt <= '0;
                        if (r_bit_cnt != c_BITCNT_MAX) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                        if (r_state == ST_ACK) begin
                            // Fall 11: device pulls data low to acknowledge
                            r_state <= r_dat_sync ? ST_ERR : ST_WAIT_IDLE;
                        end else if (r_bit_cnt < 4'd8) begin
                            // Fall k presents data bit k-1 (old count = k-1)
                            r_dat_oe <= ~r_data[r_bit_cnt[2:0]];
                        end else if (r_bit_cnt == 4'd8) begin
                            r_dat_oe <= ~r_parity;
                        end else begin
                            r_dat_oe <= 1'b0;       // stop bit: release data
                            r_state  <= ST_ACK;
                        end
                    end else if (w_timeout) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_state  <= ST_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end

                ST_WAIT_IDLE: begin
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_clk_level && r_dat_sync) begin
                        r_done <= 1'b1;
                    end else if (w_clk_fall) begin
                        r_to_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end

                ST_ERR: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (r_err) begin
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_err <= 1'b1;
                    end
                end

                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_done   <= 1'b0;
                    r_err    <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready  = r_ready;
    assign tx_done   = r_done;
    assign tx_err    = r_err;
    assign busy      = ~r_ready;
    assign ps2clk_oe = r_clk_oe;
    assign ps2dat_oe = r_dat_oe;

endmodule
`default_nettype wire
